// File: rtl/clock_pkg.sv
// Shared definitions for the clock divider / frequency meter slice.
//   REFERENCE_CLOCK : default clk_FPGA frequency in Hz
//   freq_state_t    : frequency meter FSM states
//   CeilLog2        : ceil(log2(value)), used to size counters
package clock_pkg;

    localparam int REFERENCE_CLOCK = 50_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } freq_state_t;

    // Smallest width able to hold 0..value-1 (value >= 2).
    function automatic int CeilLog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for an asynchronous input.
//   clk_FPGA  in  system clock
//   reset     in  synchronous active-high reset, clears synchronizer and history
//   signal_in in  asynchronous square wave
//   rise      out one-cycle pulse per synchronized rising edge
module edge_detector (
    input  logic clk_FPGA,
    input  logic reset,
    input  logic signal_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic hist;

    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            hist   <= 1'b0;
        end else begin
            sync_1 <= signal_in;
            sync_2 <= sync_1;
            hist   <= sync_2;
        end
    end

    assign rise = sync_2 & ~hist;

endmodule

// File: rtl/frequency_meter.sv
// Frequency meter: counts rising edges of signal_in over a gate of
// GATE_CYCLES enabled clk_FPGA cycles. With GATE_CYCLES = REFERENCE_CLOCK
// the result is in Hz.
//   clk_FPGA   in  system clock
//   reset      in  synchronous active-high reset (aborts an open gate)
//   enable     in  1: gate and edge counting advance, 0: pause
//   start      in  one-cycle measurement request, ignored while busy
//   signal_in  in  asynchronous signal to measure
//   busy       out gate open (MEASURE or DONE)
//   freq_valid out one-cycle pulse when frequency/overflow are updated
//   frequency  out edges counted in the last completed gate
//   overflow   out last result saturated at all-ones
//
// state   | meaning
// IDLE    | waiting for start with enable high
// MEASURE | gate open, counting enabled cycles and edges
// DONE    | one cycle, result registers show the new value
module frequency_meter #(
    parameter int REFERENCE_CLOCK = clock_pkg::REFERENCE_CLOCK,
    parameter int GATE_CYCLES     = REFERENCE_CLOCK,
    parameter int NBITS_FREQ      = 32,
    parameter int NBITS_GATE      = clock_pkg::CeilLog2(GATE_CYCLES),
    parameter bit CONTINUOUS      = 1'b0
) (
    input  logic                  clk_FPGA,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  signal_in,
    output logic                  busy,
    output logic                  freq_valid,
    output logic [NBITS_FREQ-1:0] frequency,
    output logic                  overflow
);

    import clock_pkg::*;

    localparam logic [NBITS_GATE-1:0] GATE_LAST = NBITS_GATE'(GATE_CYCLES - 1);
    localparam logic [NBITS_FREQ-1:0] FREQ_MAX  = '1;

    freq_state_t           state;
    freq_state_t           state_next;
    logic [NBITS_GATE-1:0] gate_cnt;
    logic [NBITS_FREQ-1:0] edge_cnt;
    logic [NBITS_FREQ-1:0] edge_cnt_next;
    logic                  sat;
    logic                  sat_next;
    logic                  rise;
    logic                  counting;
    logic                  gate_last;
    logic                  gate_open;

    edge_detector u_edge_detector (
        .clk_FPGA  (clk_FPGA),
        .reset     (reset),
        .signal_in (signal_in),
        .rise      (rise)
    );

    assign counting  = (state == MEASURE) && enable;
    assign gate_last = counting && (gate_cnt == GATE_LAST);

    // Edge count including this cycle's pulse, so an edge on the final
    // gate cycle still lands in the result.
    always_comb begin
        edge_cnt_next = edge_cnt;
        sat_next      = sat;
        if (counting && rise) begin
            if (edge_cnt == FREQ_MAX) begin
                sat_next = 1'b1;
            end else begin
                edge_cnt_next = edge_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        gate_open  = 1'b0;
        case (state)
            IDLE: begin
                if (start && enable) begin
                    state_next = MEASURE;
                    gate_open  = 1'b1;
                end
            end
            MEASURE: begin
                if (gate_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (CONTINUOUS) begin
                    state_next = MEASURE;
                    gate_open  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            frequency  <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= gate_last;
            if (gate_open) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (counting) begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_cnt_next;
                sat      <= sat_next;
            end
            if (gate_last) begin
                frequency <= edge_cnt_next;
                overflow  <= sat_next;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_frequency_meter.sv
module tb_frequency_meter;

    localparam int G = 100;
    localparam int N = 3000;

    logic clk_FPGA = 1'b0;
    always #5 clk_FPGA = ~clk_FPGA;

    logic reset, enable, start, signal_in;
    logic busy0, fv0, ovf0;
    logic [31:0] freq0;
    logic busy1, fv1, ovf1;
    logic [3:0] freq1;
    logic busy2, fv2, ovf2;
    logic [31:0] freq2;

    frequency_meter #(.GATE_CYCLES(G)) dut_main (
        .clk_FPGA(clk_FPGA), .reset(reset), .enable(enable), .start(start),
        .signal_in(signal_in), .busy(busy0), .freq_valid(fv0),
        .frequency(freq0), .overflow(ovf0));

    frequency_meter #(.GATE_CYCLES(G), .NBITS_FREQ(4)) dut_narrow (
        .clk_FPGA(clk_FPGA), .reset(reset), .enable(enable), .start(start),
        .signal_in(signal_in), .busy(busy1), .freq_valid(fv1),
        .frequency(freq1), .overflow(ovf1));

    frequency_meter #(.GATE_CYCLES(G), .CONTINUOUS(1'b1)) dut_cont (
        .clk_FPGA(clk_FPGA), .reset(reset), .enable(enable), .start(start),
        .signal_in(signal_in), .busy(busy2), .freq_valid(fv2),
        .frequency(freq2), .overflow(ovf2));

    typedef struct packed {
        int          cyc;
        logic [63:0] freq;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bit s_a[N];
    bit en_a[N];
    bit st_a[N];
    bit rst_a[N];
    bit busy_exp[3][N];

    logic [63:0] held_f[3];
    logic        held_o[3];

    int vectors = 0;
    int errors  = 0;
    int cur     = -1;
    bit done    = 1'b0;

    // Synchronizer view of the input: a reset clears the flops, so a sample
    // taken at a reset edge never reaches the edge detector.
    function automatic bit eff(input int k);
        if (k < 0 || k >= N) return 1'b0;
        return s_a[k] && !rst_a[k];
    endfunction

    // A rise sampled at edge j-2 is counted at edge j.
    function automatic bit rise_at(input int j);
        return eff(j - 2) && !eff(j - 3);
    endfunction

    task automatic push_exp(input int inst, input exp_t e);
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic fill_sq(input int from, input int to, input int period);
        for (int k = from; k <= to; k++) s_a[k] = ((k - from) % period) < (period / 2);
    endtask

    // Walks the stimulus as a sequence of gates: a gate begins at an
    // accepted start, spans G enabled cycles, and reports at its last one.
    task automatic run_model(input int inst, input int nb, input bit cont);
        int t, j, k, cnt, edges;
        bit abort, running;
        longint maxv;
        exp_t e;
        maxv = (longint'(1) << nb) - 1;
        for (int i = 0; i < N; i++) busy_exp[inst][i] = 1'b0;
        k = 0;
        while (k < N) begin
            if (!rst_a[k] && st_a[k] && en_a[k]) begin
                t = k;
                running = 1'b1;
                while (running) begin
                    busy_exp[inst][t] = 1'b1;
                    j = t + 1; cnt = 0; edges = 0; abort = 1'b0;
                    while (cnt < G && j < N && !abort) begin
                        if (rst_a[j]) begin
                            abort = 1'b1;
                        end else begin
                            busy_exp[inst][j] = 1'b1;
                            if (en_a[j]) begin
                                cnt++;
                                if (rise_at(j)) edges++;
                            end
                            j++;
                        end
                    end
                    if (abort) begin
                        k = j + 1; running = 1'b0;
                    end else if (cnt < G) begin
                        k = N; running = 1'b0;
                    end else begin
                        e.cyc  = j - 1;
                        e.freq = (longint'(edges) > maxv) ? maxv : longint'(edges);
                        e.ovf  = (longint'(edges) > maxv);
                        push_exp(inst, e);
                        if (cont && (j < N) && !rst_a[j]) t = j;
                        else begin k = j + 1; running = 1'b0; end
                    end
                end
            end else begin
                k++;
            end
        end
    endtask

    task automatic check_inst(input int inst, input int k, input bit fv, input bit bsy,
                              input logic [63:0] fq, input bit ov);
        exp_t e;
        bit exp_v;
        exp_v = 1'b0;
        e = '0;
        case (inst)
            0: if (q0.size() > 0 && q0[0].cyc == k) begin exp_v = 1'b1; e = q0.pop_front(); end
            1: if (q1.size() > 0 && q1[0].cyc == k) begin exp_v = 1'b1; e = q1.pop_front(); end
            default: if (q2.size() > 0 && q2[0].cyc == k) begin exp_v = 1'b1; e = q2.pop_front(); end
        endcase
        if (rst_a[k]) begin held_f[inst] = '0; held_o[inst] = 1'b0; end
        if (exp_v) begin held_f[inst] = e.freq; held_o[inst] = e.ovf; end

        vectors++;
        if (fv !== exp_v) begin
            errors++;
            $display("FAIL freq_valid inst%0d cycle %0d: got %0b expected %0b", inst, k, fv, exp_v);
        end
        vectors++;
        if (fq !== held_f[inst] || ov !== held_o[inst]) begin
            errors++;
            $display("FAIL result inst%0d cycle %0d: got freq=%0d ovf=%0b expected freq=%0d ovf=%0b",
                     inst, k, fq, ov, held_f[inst], held_o[inst]);
        end
        vectors++;
        if (bsy !== busy_exp[inst][k]) begin
            errors++;
            $display("FAIL busy inst%0d cycle %0d: got %0b expected %0b", inst, k, bsy, busy_exp[inst][k]);
        end
    endtask

    // Monitor: samples every negedge, between driver updates.
    initial begin
        for (int i = 0; i < 3; i++) begin held_f[i] = '0; held_o[i] = 1'b0; end
        forever begin
            @(negedge clk_FPGA);
            if (!done && cur >= 0) begin
                check_inst(0, cur, fv0, busy0, {32'd0, freq0}, ovf0);
                check_inst(1, cur, fv1, busy1, {60'd0, freq1}, ovf1);
                check_inst(2, cur, fv2, busy2, {32'd0, freq2}, ovf2);
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            s_a[k] = 1'b0; en_a[k] = 1'b1; st_a[k] = 1'b0; rst_a[k] = 1'b0;
        end
        // reset held with the input toggling
        for (int k = 0; k < 4; k++) begin rst_a[k] = 1'b1; s_a[k] = (k % 2 == 0); end
        // period 10, single run, result held for a long while
        fill_sq(4, 399, 10);
        st_a[10] = 1'b1;
        // constant 0, then constant 1
        st_a[410] = 1'b1;
        for (int k = 550; k < 700; k++) s_a[k] = 1'b1;
        st_a[560] = 1'b1;
        // period 2 (saturates the narrow meter), then period 10
        fill_sq(700, 899, 2);
        st_a[710] = 1'b1;
        fill_sq(900, 1099, 10);
        st_a[910] = 1'b1;
        // start while busy, pause mid-gate
        fill_sq(1100, 1399, 10);
        st_a[1110] = 1'b1;
        st_a[1150] = 1'b1;
        for (int k = 1160; k < 1180; k++) en_a[k] = 1'b0;
        // reset mid-gate
        fill_sq(1400, 1599, 10);
        st_a[1410] = 1'b1;
        rst_a[1460] = 1'b1;
        // randomized tail
        for (int k = 1600; k < N; k++) begin
            s_a[k]   = ($urandom_range(0, 2) == 0) ? ~s_a[k-1] : s_a[k-1];
            en_a[k]  = ($urandom_range(0, 9) != 0);
            st_a[k]  = ($urandom_range(0, 29) == 0);
            rst_a[k] = ($urandom_range(0, 499) == 0);
        end
        fill_sq(2000, 2299, 2);

        run_model(0, 32, 1'b0);
        run_model(1, 4, 1'b0);
        run_model(2, 32, 1'b1);

        reset = rst_a[0]; enable = en_a[0]; start = st_a[0]; signal_in = s_a[0];
        for (int k = 0; k < N; k++) begin
            @(posedge clk_FPGA);
            #1;
            cur = k;
            if (k + 1 < N) begin
                reset = rst_a[k+1]; enable = en_a[k+1]; start = st_a[k+1]; signal_in = s_a[k+1];
            end
        end
        @(posedge clk_FPGA);
        #1;
        done = 1'b1;

        vectors++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL leftover results: got %0d unconsumed expected 0", q0.size() + q1.size() + q2.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
